camera_pixel_buffer: RTL

//  Elastic RGB565 pixel FIFO between OV7670_Ctrl (newPixel/pixelData strobes) and ILI9341_Driver
//  (pops one pixel per request). Absorbs camera line bursts vs. SPI drain rate, tags start-of-frame,

---
 rtl/camera_buffer_pkg.sv | 10 +
 rtl/pixel_buffer_ram.sv | 23 ++
 rtl/camera_pixel_buffer.sv | 108 ++++++++++
 3 files changed

// File: rtl/camera_buffer_pkg.sv
// camera_buffer_pkg: shared types for the camera pixel FIFO (tagged pixel word, flow-state enum).
package camera_buffer_pkg;
  localparam int STAT_W = 16;
  typedef logic [15:0] pixel_t;
  typedef struct packed {
    logic   sof;
    pixel_t pixel;
  } buf_word_t;
  typedef enum logic [1:0] {WAIT_SOF, STREAM, RESYNC} buf_state_t;
endpackage

// File: rtl/pixel_buffer_ram.sv
// pixel_buffer_ram: simple dual-port RAM, one write port, one registered read port.
module pixel_buffer_ram #(
  parameter int W     = 17,
  parameter int WORDS = 511,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem_q [WORDS];
  logic [W-1:0] rd_data_q;
  // Read returns the old word when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/camera_pixel_buffer.sv
// camera_pixel_buffer: elastic RGB565 FIFO with SOF tagging and drop-to-next-frame on overflow.
// Optional stats counters enabled by defining CAMERA_PIXEL_BUFFER_STATS_EN.
module camera_pixel_buffer
  import camera_buffer_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int DATA_W      = 16,
  parameter int AFULL_LEVEL = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frameStart,
  input  logic                     newPixel,
  input  logic [DATA_W-1:0]        pixelDataIn,
  input  logic                     pixelReq,
  output logic [DATA_W-1:0]        pixelDataOut,
  output logic                     pixelValid,
  output logic                     frameSync,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almostFull,
  output logic                     overflow,
  output logic [15:0]              droppedCount,
  output logic [15:0]              frameCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 2) ? '0 : p + 1'b1;
  endfunction
  buf_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic out_valid_q, out_valid_d, sof_pend_q, sof_pend_d, overflow_q, overflow_d;
  logic pop, streaming, full, wr_en, drop, rd_en;
  buf_word_t wr_word, rd_word;
  always_comb begin
    pop         = pixelReq && out_valid_q;
    streaming   = frameStart || state_q == STREAM;
    full        = count_q == CW'(DEPTH);
    wr_en       = newPixel && streaming && (!full || pop);
    drop        = newPixel && streaming && full && !pop;
    rd_en       = count_q != {{AW{1'b0}}, out_valid_q} && (!out_valid_q || pop);
    state_d     = drop ? RESYNC : streaming ? STREAM : state_q;
    sof_pend_d  = (frameStart || sof_pend_q) && !wr_en;
    wr_ptr_d    = wr_en ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_en ? nxt(rd_ptr_q) : rd_ptr_q;
    out_valid_d = rd_en || (out_valid_q && !pop);
    count_d     = count_q + CW'(wr_en) - CW'(pop);
    overflow_d  = overflow_q || drop;
    wr_word     = '{sof: frameStart || sof_pend_q, pixel: pixelDataIn};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      sof_pend_q  <= sof_pend_d;
      overflow_q  <= overflow_d;
    end
  end
  // The RAM read register doubles as the output register.
  pixel_buffer_ram #(.W($bits(buf_word_t)), .WORDS(DEPTH - 1), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );
  assign pixelDataOut = out_valid_q ? rd_word.pixel : '0;
  assign pixelValid   = out_valid_q;
  assign frameSync    = out_valid_q && rd_word.sof;
  assign count        = count_q;
  assign almostFull   = count_q >= CW'(AFULL_LEVEL);
  assign overflow     = overflow_q;
`ifdef CAMERA_PIXEL_BUFFER_STATS_EN
  logic [STAT_W-1:0] dropped_q, dropped_d, frames_q, frames_d;
  always_comb begin
    dropped_d = (drop && dropped_q != '1) ? dropped_q + 1'b1 : dropped_q;
    frames_d  = frames_q + STAT_W'(frameStart);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q <= '0;
      frames_q  <= '0;
    end else begin
      dropped_q <= dropped_d;
      frames_q  <= frames_d;
    end
  end
  assign droppedCount = dropped_q;
  assign frameCount   = frames_q;
`else
  assign droppedCount = '0;
  assign frameCount   = '0;
`endif
endmodule
